instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Parametrised successor to the hard-coded program-counter/instruction-memory front end.
- Holds a writable instruction memory, loaded word by word from the bench or a host before run.
- A program counter with start/run/halt control supplies one registered instruction per advance to the control unit.
- Adds jump, program length, wrap-or-halt end mode, and fault reporting.

Parameters:
- INSTR_WIDTH, 8, instruction word width in bits.
- ADDR_WIDTH, 4, program counter / memory address width.
- DEPTH, 16, number of memory words. Constraint: DEPTH <= 2**ADDR_WIDTH.
- WRAP, 1. When 1, the PC wraps to 0 after the last instruction. When 0, the unit halts.
- NOP, 0, INSTR_WIDTH-bit word driven when no valid instruction is present (move r0 to r0).

Ports:
- clock  in  1  single system clock, rising edge.
- resetnot  in  1  asynchronous active-low reset.
- load_en  in  1  write load_data to memory at load_addr this cycle (IDLE/HALT only).
- load_addr  in  ADDR_WIDTH  memory write address.
- load_data  in  INSTR_WIDTH  memory write data.
- prog_len  in  ADDR_WIDTH+1  number of valid program words, sampled on start.
- start  in  1  begin execution at address 0.
- increment  in  1  synchronous advance request, one step per cycle held high.
- jump  in  1  load PC from jump_target; has priority over increment.
- jump_target  in  ADDR_WIDTH  jump destination.
- instruction  out  INSTR_WIDTH  registered current instruction.
- pc  out  ADDR_WIDTH  registered current program counter.
- valid  out  1  instruction is a live program word.
- halted  out  1  unit is in HALT.
- fault  out  1  sticky flag: jump out of range or zero-length start.

Behaviour:
- Reset (resetnot low, asynchronous):
  - state=IDLE, pc=0, instruction=NOP, valid=0, halted=0, fault=0, latched length=0.
  - All memory words are cleared to NOP.
  - Reset mid-run aborts immediately with no partial update.
- States: IDLE, RUN, HALT.
- IDLE/HALT:
  - load_en writes mem[load_addr]=load_data on the edge.
  - Writes with load_addr >= DEPTH are ignored.
  - A load and a start on the same cycle: the write happens, and the instruction fetched at address 0 sees the new data if load_addr==0 (write-through).
- start in IDLE or HALT:
  - Latch len=prog_len (values above DEPTH are clamped to DEPTH).
  - If len==0: go to HALT, fault=1, valid=0.
  - Otherwise: go to RUN, pc=0, instruction=mem[0], valid=1, halted=0; fault is cleared.
  - start while in RUN is ignored.
- RUN: load_en is ignored and memory does not change. On each edge, in priority order:
  1. jump:
     - If jump_target < len: pc=jump_target, instruction=mem[jump_target].
     - Otherwise: HALT, fault=1, valid=0, instruction=NOP, pc unchanged.
  2. increment, when pc < len-1: pc=pc+1, instruction=mem[pc+1].
  3. increment, when pc == len-1:
     - WRAP=1: pc=0, instruction=mem[0], valid stays 1.
     - WRAP=0: HALT, halted=1, valid=0, instruction=NOP, pc holds len-1.
  4. No request: all outputs hold.
- Latency:
  - pc and instruction update on the same edge that samples the request.
  - instruction always equals mem[pc] while valid=1.
  - No bubble between consecutive increments: one instruction per cycle.
- Arithmetic: pc addition is ADDR_WIDTH wide. For len==2**ADDR_WIDTH, the WRAP=1 wrap equals natural overflow.
- HALT: halted=1, valid=0, instruction=NOP. Only start or reset leaves HALT.
- fault is sticky until the next successful start or reset.

Test Plan:
- Load 12 words (0xB1,0xD7,0x05,0x56,0x5F,0xCF,0x8D,0xCD,0x0D,0x05,0x01,0xCC), prog_len=12, WRAP=1, start, then 12 increments -> instruction 0xB1 then 0xD7…0xCC, pc 0..11, then pc=0, instruction=0xB1, valid held 1 throughout.
- Same program with WRAP=0: increment at pc=11 -> halted=1, valid=0, instruction=0x00, pc=11. A further increment changes nothing. start -> pc=0, instruction=0xB1.
- In RUN, assert jump=1, jump_target=6 and increment=1 together -> pc=6, instruction=0x8D (jump wins). jump_target=13 -> HALT, fault=1, pc unchanged.
- Load in RUN: load_en, addr=0, data=0xFF -> ignored. After halt, reload and restart: instruction=0xFF. Load at addr 0 in the same cycle as start -> first instruction equals the new data.
- prog_len=0 with start -> HALT, fault=1, valid=0. Then prog_len=1, start, increment x3 (WRAP=1) -> pc stays 0, instruction=mem[0].
- Pulse resetnot low mid-run between clock edges -> outputs go to pc=0, instruction=0x00, valid=0 immediately. Memory reads back as NOP after a restart with prog_len=4.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: writable program memory feeding a PC with start/run/halt control.
// pc and instruction update on the edge that samples the request; one word per cycle, never stalls.
module instr_fetch_unit #(
  parameter int                     INSTR_WIDTH = 8,
  parameter int                     ADDR_WIDTH  = 4,
  parameter int                     DEPTH       = 16,
  parameter bit                     WRAP        = 1'b1,
  parameter logic [INSTR_WIDTH-1:0] NOP         = '0
) (
  input  logic                   clock,
  input  logic                   resetnot,
  input  logic                   load_en,
  input  logic [ADDR_WIDTH-1:0]  load_addr,
  input  logic [INSTR_WIDTH-1:0] load_data,
  input  logic [ADDR_WIDTH:0]    prog_len,
  input  logic                   start,
  input  logic                   increment,
  input  logic                   jump,
  input  logic [ADDR_WIDTH-1:0]  jump_target,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic [ADDR_WIDTH-1:0]  pc,
  output logic                   valid,
  output logic                   halted,
  output logic                   fault
);

  localparam int              LW      = ADDR_WIDTH + 1;
  localparam logic [LW-1:0]   DEPTH_L = LW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [INSTR_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0]  pc_nxt;
  logic [ADDR_WIDTH-1:0]  pc_inc;
  logic [INSTR_WIDTH-1:0] instr_nxt;
  logic [INSTR_WIDTH-1:0] mem0_thru;
  logic                   valid_nxt;
  logic                   fault_nxt;
  logic                   load_ok;
  logic                   at_last;
  logic [LW-1:0]          len_q;
  logic [LW-1:0]          len_nxt;
  logic [LW-1:0]          len_clamp;

  assign load_ok   = load_en && (state != RUN) && ({1'b0, load_addr} < DEPTH_L);
  // A load to word 0 on the start edge must be visible in the first fetch.
  assign mem0_thru = (load_ok && (load_addr == '0)) ? load_data : mem[0];
  assign len_clamp = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
  assign pc_inc    = pc + ADDR_WIDTH'(1);
  assign at_last   = ({1'b0, pc} == (len_q - LW'(1)));
  assign halted    = (state == HALT);

  always_ff @(posedge clock or negedge resetnot) begin
    if (!resetnot) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= NOP;
      end
    end else if (load_ok) begin
      mem[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clock or negedge resetnot) begin
    if (!resetnot) begin
      state       <= IDLE;
      pc          <= '0;
      instruction <= NOP;
      valid       <= 1'b0;
      fault       <= 1'b0;
      len_q       <= '0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      instruction <= instr_nxt;
      valid       <= valid_nxt;
      fault       <= fault_nxt;
      len_q       <= len_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    instr_nxt = instruction;
    valid_nxt = valid;
    fault_nxt = fault;
    len_nxt   = len_q;
    case (state)
      IDLE, HALT: begin
        if (start) begin
          len_nxt = len_clamp;
          if (len_clamp == '0) begin
            state_nxt = HALT;
            fault_nxt = 1'b1;
            valid_nxt = 1'b0;
            instr_nxt = NOP;
          end else begin
            state_nxt = RUN;
            pc_nxt    = '0;
            instr_nxt = mem0_thru;
            valid_nxt = 1'b1;
            fault_nxt = 1'b0;
          end
        end
      end
      RUN: begin
        if (jump) begin
          if ({1'b0, jump_target} < len_q) begin
            pc_nxt    = jump_target;
            instr_nxt = mem[jump_target];
          end else begin
            state_nxt = HALT;
            fault_nxt = 1'b1;
            valid_nxt = 1'b0;
            instr_nxt = NOP;
          end
        end else if (increment) begin
          if (!at_last) begin
            pc_nxt    = pc_inc;
            instr_nxt = mem[pc_inc];
          end else if (WRAP) begin
            pc_nxt    = '0;
            instr_nxt = mem[0];
          end else begin
            state_nxt = HALT;
            valid_nxt = 1'b0;
            instr_nxt = NOP;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        valid_nxt = 1'b0;
        instr_nxt = NOP;
      end
    endcase
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a wrapping and a halting instance share one stimulus stream and are
// compared against a program-level model, directed tables and hand sequences.
module tb_instr_fetch_unit;
  localparam int AW = 4;
  localparam int IW = 8;
  localparam int D  = 16;
  localparam int IDLEM = 0;
  localparam int RUNM  = 1;
  localparam int HALTM = 2;

  logic          clock = 1'b0;
  logic          resetnot;
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [IW-1:0] load_data;
  logic [AW:0]   prog_len;
  logic          start;
  logic          increment;
  logic          jump;
  logic [AW-1:0] jump_target;

  logic [IW-1:0] instr_o  [2];
  logic [AW-1:0] pc_o     [2];
  logic          valid_o  [2];
  logic          halted_o [2];
  logic          fault_o  [2];

  instr_fetch_unit #(.INSTR_WIDTH(IW), .ADDR_WIDTH(AW), .DEPTH(D), .WRAP(1'b0), .NOP(8'h00)) u_halt (
    .clock(clock), .resetnot(resetnot), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .prog_len(prog_len), .start(start), .increment(increment),
    .jump(jump), .jump_target(jump_target), .instruction(instr_o[0]), .pc(pc_o[0]),
    .valid(valid_o[0]), .halted(halted_o[0]), .fault(fault_o[0])
  );

  instr_fetch_unit #(.INSTR_WIDTH(IW), .ADDR_WIDTH(AW), .DEPTH(D), .WRAP(1'b1), .NOP(8'h00)) u_wrap (
    .clock(clock), .resetnot(resetnot), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .prog_len(prog_len), .start(start), .increment(increment),
    .jump(jump), .jump_target(jump_target), .instruction(instr_o[1]), .pc(pc_o[1]),
    .valid(valid_o[1]), .halted(halted_o[1]), .fault(fault_o[1])
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Program-level model, index 0 = halting instance, 1 = wrapping instance.
  logic [IW-1:0] mm [2][D];
  int            m_st [2];
  int            m_pc [2];
  int            m_len [2];
  bit            m_fault [2];

  logic [IW-1:0] prog [12] = '{8'hB1, 8'hD7, 8'h05, 8'h56, 8'h5F, 8'hCF,
                               8'h8D, 8'hCD, 8'h0D, 8'h05, 8'h01, 8'hCC};

  typedef struct {
    bit            st;
    bit            inc;
    bit            jmp;
    logic [AW-1:0] tgt;
    logic [AW-1:0] e_pc;
    logic [IW-1:0] e_instr;
    bit            e_valid;
    bit            e_fault;
  } vec_t;
  vec_t tbl [16];

  task automatic chk(input string name, input int w, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s[d%0d] actual=%0h required=%0h", name, w, act, req);
    end
  endtask

  task automatic model_reset();
    for (int w = 0; w < 2; w++) begin
      for (int a = 0; a < D; a++) mm[w][a] = '0;
      m_st[w] = IDLEM;
      m_pc[w] = 0;
      m_len[w] = 0;
      m_fault[w] = 1'b0;
    end
  endtask

  task automatic model_update();
    for (int w = 0; w < 2; w++) begin
      if (m_st[w] != RUNM) begin
        if (load_en) mm[w][load_addr] = load_data;
        if (start) begin
          m_len[w] = (int'(prog_len) > D) ? D : int'(prog_len);
          if (m_len[w] == 0) begin
            m_st[w] = HALTM;
            m_fault[w] = 1'b1;
          end else begin
            m_st[w] = RUNM;
            m_pc[w] = 0;
            m_fault[w] = 1'b0;
          end
        end
      end else if (jump) begin
        if (int'(jump_target) < m_len[w]) m_pc[w] = int'(jump_target);
        else begin
          m_st[w] = HALTM;
          m_fault[w] = 1'b1;
        end
      end else if (increment) begin
        if (m_pc[w] + 1 < m_len[w]) m_pc[w] = m_pc[w] + 1;
        else if (w == 1) m_pc[w] = 0;
        else m_st[w] = HALTM;
      end
    end
  endtask

  task automatic check_all();
    for (int w = 0; w < 2; w++) begin
      logic [31:0] ei;
      ei = (m_st[w] == RUNM) ? 32'(mm[w][m_pc[w]]) : 32'h0;
      chk("pc", w, 32'(pc_o[w]), 32'(m_pc[w]));
      chk("instruction", w, 32'(instr_o[w]), ei);
      chk("valid", w, 32'(valid_o[w]), 32'(m_st[w] == RUNM));
      chk("halted", w, 32'(halted_o[w]), 32'(m_st[w] == HALTM));
      chk("fault", w, 32'(fault_o[w]), 32'(m_fault[w]));
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    model_update();
    @(negedge clock);
    check_all();
  endtask

  task automatic idle_inputs();
    load_en = 1'b0; load_addr = '0; load_data = '0; start = 1'b0;
    increment = 1'b0; jump = 1'b0; jump_target = '0;
  endtask

  // Called at a falling edge; reset is pulsed and released before the next rising edge.
  task automatic reset_pulse();
    #1 resetnot = 1'b0;
    #1;
    for (int w = 0; w < 2; w++) begin
      chk("rst_pc", w, 32'(pc_o[w]), 32'h0);
      chk("rst_instruction", w, 32'(instr_o[w]), 32'h0);
      chk("rst_valid", w, 32'(valid_o[w]), 32'h0);
    end
    model_reset();
    #1 resetnot = 1'b1;
    cyc();
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 8'hB1, 1'b1, 1'b0};
    for (int i = 1; i < 12; i++) tbl[i] = '{1'b0, 1'b1, 1'b0, 4'd0, 4'(i), prog[i], 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 4'd0,  4'd0, 8'hB1, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 1'b1, 4'd6,  4'd6, 8'h8D, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 4'd0,  4'd7, 8'hCD, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 1'b1, 4'd13, 4'd7, 8'h00, 1'b0, 1'b1};

    resetnot = 1'b0;
    prog_len = '0;
    idle_inputs();
    model_reset();
    #3;
    check_all();
    for (int w = 0; w < 2; w++) chk("rst_halted", w, 32'(halted_o[w]), 32'h0);
    @(negedge clock);
    resetnot = 1'b1;

    for (int i = 0; i < 12; i++) begin
      load_en = 1'b1; load_addr = 4'(i); load_data = prog[i];
      cyc();
    end
    idle_inputs();
    prog_len = 5'd12;

    for (int i = 0; i < 16; i++) begin
      start = tbl[i].st; increment = tbl[i].inc; jump = tbl[i].jmp; jump_target = tbl[i].tgt;
      cyc();
      chk("tbl_pc", 1, 32'(pc_o[1]), 32'(tbl[i].e_pc));
      chk("tbl_instruction", 1, 32'(instr_o[1]), 32'(tbl[i].e_instr));
      chk("tbl_valid", 1, 32'(valid_o[1]), 32'(tbl[i].e_valid));
      chk("tbl_fault", 1, 32'(fault_o[1]), 32'(tbl[i].e_fault));
    end
    idle_inputs();

    // Halting instance stopped on the last word and ignores further increments.
    chk("halt_end_pc", 0, 32'(pc_o[0]), 32'd11);
    chk("halt_end_halted", 0, 32'(halted_o[0]), 32'd1);
    increment = 1'b1;
    cyc();
    chk("halt_hold_pc", 0, 32'(pc_o[0]), 32'd11);
    chk("halt_hold_instruction", 0, 32'(instr_o[0]), 32'h00);
    increment = 1'b0; start = 1'b1;
    cyc();
    chk("restart_instruction", 0, 32'(instr_o[0]), 32'hB1);
    chk("restart_fault_clear", 1, 32'(fault_o[1]), 32'd0);
    start = 1'b0;

    // Loads during RUN are dropped.
    load_en = 1'b1; load_addr = '0; load_data = 8'hFF;
    cyc();
    chk("run_load_ignored", 1, 32'(instr_o[1]), 32'hB1);
    load_en = 1'b0; jump = 1'b1; jump_target = 4'd13;
    cyc();
    jump = 1'b0; load_en = 1'b1;
    cyc();
    load_en = 1'b0; start = 1'b1;
    cyc();
    chk("reload_instruction", 1, 32'(instr_o[1]), 32'hFF);
    start = 1'b0; jump = 1'b1; jump_target = 4'd15;
    cyc();
    jump = 1'b0; load_en = 1'b1; load_data = 8'h42; start = 1'b1;
    cyc();
    chk("load_start_thru", 0, 32'(instr_o[0]), 32'h42);
    chk("load_start_thru", 1, 32'(instr_o[1]), 32'h42);
    idle_inputs();

    jump = 1'b1; jump_target = 4'd14;
    cyc();
    jump = 1'b0; prog_len = '0; start = 1'b1;
    cyc();
    chk("zero_len_halted", 1, 32'(halted_o[1]), 32'd1);
    chk("zero_len_fault", 1, 32'(fault_o[1]), 32'd1);
    chk("zero_len_valid", 1, 32'(valid_o[1]), 32'd0);
    prog_len = 5'd1;
    cyc();
    start = 1'b0; increment = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("len1_pc", 1, 32'(pc_o[1]), 32'd0);
      chk("len1_instruction", 1, 32'(instr_o[1]), 32'h42);
    end
    idle_inputs();

    // Reset mid-run, then confirm memory came back as NOP.
    prog_len = 5'd12; start = 1'b1;
    cyc();
    start = 1'b0; increment = 1'b1;
    repeat (3) cyc();
    reset_pulse();
    idle_inputs();
    prog_len = 5'd4; start = 1'b1;
    cyc();
    chk("post_rst_instruction", 1, 32'(instr_o[1]), 32'h00);
    chk("post_rst_valid", 1, 32'(valid_o[1]), 32'd1);
    start = 1'b0; increment = 1'b1;
    repeat (5) cyc();

    for (int n = 0; n < 600; n++) begin
      start       = ($urandom_range(0, 11) == 0);
      load_en     = ($urandom_range(0, 2) == 0);
      load_addr   = 4'($urandom);
      load_data   = 8'($urandom);
      prog_len    = 5'($urandom_range(0, 20));
      increment   = 1'($urandom_range(0, 1));
      jump        = ($urandom_range(0, 9) == 0);
      jump_target = 4'($urandom);
      if ($urandom_range(0, 149) == 0) reset_pulse();
      else cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
